io_loader: RTL and testbench

Byte-stream memory loader placed directly upstream of the instruction/data memory I/O selector. It accepts a narrow byte stream from the FPGA pin interface (UART receiver or debug port) and decodes a command header. It assembles 32-bit little-endian words and drives the selector's `selector`/`data_in` inputs, together with a write address and write strobe, to fill either instruction memory or data memory before the core is released.

---
 rtl/io_loader.sv | 137 +++++++++++++
 tb/tb_io_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/io_loader.sv
// Byte-stream memory loader: decodes a CMD/LEN header, assembles little-endian
// words and drives the I/O selector with a write address and one-cycle strobe.
module io_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  selector,
  output logic [WIDTH-1:0]      data_in,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LANE_W = 2;
  localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    count;
  logic [LANE_W-1:0]   lane;
  logic                accept;
  logic                cmd_ok;
  logic [CNT_W-1:0]    len;
  logic                len_zero;
  logic                len_over;

  assign accept   = rx_valid && rx_ready;
  assign cmd_ok   = (rx_data == 8'hA0) || (rx_data == 8'hA1);
  // Full frame length as seen while the high byte is on the bus
  assign len      = {rx_data, count[7:0]};
  assign len_zero = (len == '0);
  assign len_over = {1'b0, len} > DEPTH;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept && cmd_ok) state_nxt = S_LEN_LO;
      S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_zero)      state_nxt = S_DONE;
          else if (len_over) state_nxt = S_IDLE;
          else               state_nxt = S_DATA;
        end
      end
      S_DATA:   if (accept && (lane == 2'd3)) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (count == CNT_W'(1)) ? S_DONE : S_DATA;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Byte acceptance is purely a function of state
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA: rx_ready = 1'b1;
      default:                            rx_ready = 1'b0;
    endcase
  end

  // Registered datapath; strobes are decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selector <= 1'b0;
      data_in  <= '0;
      wr_addr  <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      lane     <= '0;
    end else begin
      wr_en <= (state_nxt == S_WRITE);
      done  <= (state_nxt == S_DONE);
      busy  <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cmd_ok) begin
              selector <= rx_data[0];
              err      <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LEN_LO: if (accept) count[7:0] <= rx_data;
        S_LEN_HI: begin
          if (accept) begin
            count[15:8] <= rx_data;
            lane        <= '0;
            wr_addr     <= '0;
            if (!len_zero && len_over) err <= 1'b1;
          end
        end
        S_DATA: begin
          if (accept) begin
            data_in[{lane, 3'b000} +: 8] <= rx_data;
            lane                         <= LANE_W'(lane + 2'd1);
          end
        end
        S_WRITE: begin
          wr_addr <= ADDR_WIDTH'(wr_addr + ADDR_WIDTH'(1));
          count   <= CNT_W'(count - CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_loader.sv
// Directed bench for io_loader: frame loads, stalls, zero length, bad/oversize
// commands and mid-frame reset, with writes captured by a negedge monitor.
module tb_io_loader;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned ENT_W      = WIDTH + ADDR_WIDTH + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  selector;
  logic [WIDTH-1:0]      data_in;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;
  logic                  busy;
  logic                  done;
  logic                  err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [ENT_W-1:0] wq[$];

  always #5 clk = ~clk;

  io_loader #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .selector(selector), .data_in(data_in),
    .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy), .done(done), .err(err)
  );

  // Capture every write strobe and done pulse mid-cycle
  always @(negedge clk) begin
    if (wr_en) wq.push_back({selector, wr_addr, data_in});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 64'(1));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic sel,
                             input logic [ADDR_WIDTH-1:0] addr, input logic [WIDTH-1:0] data);
    logic [ENT_W-1:0] e;
    if (wq.size() == 0) begin
      chk({tag, "_missing"}, 64'(wq.size()), 64'(1));
    end else begin
      e = wq.pop_front();
      chk(tag, 64'(e), 64'({sel, addr, data}));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_selector", 64'(selector), 64'(0));
    chk("rst_data_in", 64'(data_in), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_flags", 64'({wr_en, busy, done, err}), 64'(0));
    rst_n = 1'b1;
    idle(1);
    chk("rst_rx_ready", 64'(rx_ready), 64'(1));

    // Instruction load of two words
    send(8'hA0);
    chk("f1_busy", 64'(busy), 64'(1));
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("f1_w0_wr_en", 64'({wr_en, rx_ready}), 64'(2'b10));
    chk("f1_w0_data", 64'(data_in), 64'(32'h12345678));
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("f1_w1_addr", 64'(wr_addr), 64'(1));
    idle(1);
    chk("f1_done", 64'({done, busy, wr_en}), 64'(3'b110));
    idle(1);
    chk("f1_idle", 64'({done, busy}), 64'(0));
    check_write("f1_write0", 1'b0, 10'd0, 32'h12345678);
    check_write("f1_write1", 1'b0, 10'd1, 32'hDEADBEEF);

    // Data load with rx_valid low every other cycle
    send(8'hA1); idle(1);
    chk("f2_selector", 64'(selector), 64'(1));
    send(8'h01); idle(1);
    send(8'h00); idle(1);
    send(8'h04); idle(1);
    chk("f2_lane0_stall", 64'(data_in), 64'(32'hDEADBE04));
    idle(1);
    chk("f2_lane0_stall2", 64'(data_in), 64'(32'hDEADBE04));
    send(8'h00); idle(1);
    send(8'h00); idle(1);
    send(8'h00); idle(3);
    check_write("f2_write0", 1'b1, 10'd0, 32'h00000004);
    chk("f2_done_cnt", 64'(done_cnt), 64'(2));

    // Zero-length frame
    send(8'hA0); send(8'h00); send(8'h00);
    chk("zl_done", 64'({done, wr_en, selector}), 64'(3'b100));
    idle(1);
    chk("zl_idle", 64'({done, busy}), 64'(0));

    // Bad command, oversize length, then recovery
    send(8'h55);
    chk("bad_cmd", 64'({err, busy, rx_ready}), 64'(3'b101));
    send(8'hA1);
    chk("ovr_cmd_clears_err", 64'({err, busy}), 64'(2'b01));
    send(8'h01); send(8'h04);
    chk("ovr_len", 64'({err, busy, rx_ready}), 64'(3'b101));
    idle(2);
    chk("ovr_no_write", 64'(wq.size()), 64'(0));
    send(8'hA0);
    chk("rec_err_clear", 64'({err, busy, selector}), 64'(3'b010));
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(3);
    check_write("rec_write0", 1'b0, 10'd0, 32'h04030201);

    // Reset in the middle of a word
    send(8'hA1); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data", 64'(data_in), 64'(0));
    chk("mid_rst_flags", 64'({selector, wr_en, busy, done, err}), 64'(0));
    chk("mid_rst_addr", 64'(wr_addr), 64'(0));
    idle(1);
    rst_n = 1'b1;
    idle(1);
    chk("mid_rst_ready", 64'(rx_ready), 64'(1));
    send(8'hA0); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    idle(3);
    check_write("post_rst_write0", 1'b0, 10'd0, 32'hDDCCBBAA);

    chk("no_extra_writes", 64'(wq.size()), 64'(0));
    chk("total_done", 64'(done_cnt), 64'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
